// File: rtl/div_pkg.sv
// div_pkg: shared operand widths and the {dividend, divisor} pair type for the divider queue
package div_pkg;
  localparam int DIVIDEND_W = 4;
  localparam int DIVISOR_W = 2;
  typedef struct packed {
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0] divisor;
  } div_op_t;
endpackage

// File: rtl/divq_ram.sv
// divq_ram: DEPTH-entry operand storage, one synchronous write port and one asynchronous read port
module divq_ram import div_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input logic clk,
  input logic we,
  input logic [AW-1:0] waddr,
  input div_op_t wdata,
  input logic [AW-1:0] raddr,
  output div_op_t rdata
);
  div_op_t mem [DEPTH];
  // write the slot chosen by the queue; contents are meaningless until written
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/div_operand_queue.sv
// div_operand_queue: first-word-fall-through queue of divider operand pairs; DIVQ_DBZ_FILTER_EN drops zero-divisor pairs and pulses dbz_err
module div_operand_queue import div_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input logic clk,
  input logic rst,
  input logic in_valid,
  output logic in_ready,
  input logic [DIVIDEND_W-1:0] in_dividend,
  input logic [DIVISOR_W-1:0] in_divisor,
  output logic out_valid,
  input logic out_ready,
  output logic [DIVIDEND_W-1:0] out_dividend,
  output logic [DIVISOR_W-1:0] out_divisor,
  output logic [CW-1:0] count,
  output logic dbz_err
);
  logic [AW-1:0] rptr, wptr;
  logic push, pop, drop, wr;
  div_op_t head;
  assign in_ready = count < CW'(DEPTH);
  assign out_valid = count != '0;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
`ifdef DIVQ_DBZ_FILTER_EN
  assign drop = push & (in_divisor == '0);
  // flag a dropped zero-divisor pair for exactly the following cycle
  always_ff @(posedge clk) begin
    if (rst) dbz_err <= 1'b0;
    else dbz_err <= drop;
  end
`else
  assign drop = 1'b0;
  assign dbz_err = 1'b0;
`endif
  assign wr = push & ~drop;
  // advance pointers on accepted handshakes; count tracks stored entries only
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + CW'(wr) - CW'(pop);
    end
  end
  divq_ram #(.DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .we(wr),
    .waddr(wptr),
    .wdata('{dividend: in_dividend, divisor: in_divisor}),
    .raddr(rptr),
    .rdata(head)
  );
  assign out_dividend = out_valid ? head.dividend : '0;
  assign out_divisor = out_valid ? head.divisor : '0;
endmodule

// File: tb/tb_div_operand_queue.sv
// tb_div_operand_queue: directed checks of the operand queue; DIVQ_DBZ_FILTER_EN selects the filter expectations
module tb_div_operand_queue;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, dbz_err;
  logic [3:0] in_dividend, out_dividend;
  logic [1:0] in_divisor, out_divisor;
  logic [2:0] count;
  int total = 0;
  int bad = 0;
  int q[$];
  div_operand_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_dividend(out_dividend), .out_divisor(out_divisor),
    .count(count), .dbz_err(dbz_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic offer(input int a, input int b);
    in_valid = 1'b1;
    in_dividend = 4'(a);
    in_divisor = 2'(b);
  endtask
  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_dividend = '0; in_divisor = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_iready", in_ready, 1);
    chk("rst_odvd", out_dividend, 0);
    chk("rst_odvs", out_divisor, 0);
    chk("rst_dbz", dbz_err, 0);
    // first push latency
    offer(9, 2); out_ready = 1'b1;
    chk("lat_ovalid0", out_valid, 0);
    step();
    in_valid = 1'b0;
    chk("lat_ovalid1", out_valid, 1);
    chk("lat_dvd", out_dividend, 9);
    chk("lat_dvs", out_divisor, 2);
    chk("lat_count1", count, 1);
    step();
    chk("lat_count0", count, 0);
    chk("lat_ovalid2", out_valid, 0);
    chk("lat_zero", out_dividend, 0);
    // fill to full, fifth refused
    out_ready = 1'b0;
    offer(1, 1); step();
    offer(2, 2); step();
    offer(3, 3); step();
    chk("fill_iready3", in_ready, 1);
    offer(4, 1); step();
    chk("full_count", count, 4);
    chk("full_iready", in_ready, 0);
    offer(5, 2); step();
    chk("full_count5", count, 4);
    chk("full_hold", out_dividend, 1);
    // pop while full: no push that cycle
    offer(6, 3); out_ready = 1'b1; step();
    chk("fullpop_count", count, 3);
    chk("fullpop_head", out_dividend, 2);
    out_ready = 1'b0; step();
    chk("refill_count", count, 4);
    in_valid = 1'b0; out_ready = 1'b1;
    chk("pop_a", out_dividend, 2); chk("pop_a_dvs", out_divisor, 2); step();
    chk("pop_b", out_dividend, 3); chk("pop_b_dvs", out_divisor, 3); step();
    chk("pop_c", out_dividend, 4); chk("pop_c_dvs", out_divisor, 1); step();
    chk("pop_d", out_dividend, 6); chk("pop_d_dvs", out_divisor, 3); step();
    chk("drain_count", count, 0);
    chk("drain_ovalid", out_valid, 0);
    // steady state at count 2 with wrap
    out_ready = 1'b0;
    offer(1, 1); q.push_back(1); step();
    offer(2, 2); q.push_back(2); step();
    chk("steady_start", count, 2);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      offer(k + 3, (k % 3) + 1);
      q.push_back(k + 3);
      chk("steady_head", out_dividend, q.pop_front());
      step();
      chk("steady_count", count, 2);
    end
    in_valid = 1'b0;
    chk("steady_t0", out_dividend, 11); step();
    chk("steady_t1", out_dividend, 12); step();
    chk("steady_empty", count, 0);
    // zero divisor into empty queue
    out_ready = 1'b0;
    offer(7, 0); step();
    in_valid = 1'b0;
`ifdef DIVQ_DBZ_FILTER_EN
    chk("dbz_pulse", dbz_err, 1);
    chk("dbz_count", count, 0);
    chk("dbz_ovalid", out_valid, 0);
    step();
    chk("dbz_once", dbz_err, 0);
`else
    chk("dbz_off", dbz_err, 0);
    chk("dbz_ovalid", out_valid, 1);
    chk("dbz_dvd", out_dividend, 7);
    chk("dbz_dvs", out_divisor, 0);
    out_ready = 1'b1; step();
    chk("dbz_drained", count, 0);
    out_ready = 1'b0;
`endif
    // reset mid-operation with handshakes active
    offer(1, 1); step();
    offer(2, 1); step();
    offer(3, 1); step();
    chk("mid_count3", count, 3);
    offer(4, 1); out_ready = 1'b1; rst = 1'b1; step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("mid_count", count, 0);
    chk("mid_ovalid", out_valid, 0);
    chk("mid_odvd", out_dividend, 0);
    chk("mid_odvs", out_divisor, 0);
    chk("mid_iready", in_ready, 1);
    step();
    chk("mid_stay", count, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/div_operand_queue.md
DIV_OPERAND_QUEUE -- requirements
Module: div_operand_queue

Interface
REQ-001 SHALL have parameter: DEPTH, 4, number of operand entries buffered (power of two, >=2).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  producer offers an operand pair.
REQ-005 SHALL have port: in_ready  output  1  queue can accept a pair this cycle.
REQ-006 SHALL have port: in_dividend  input  4  dividend of offered pair.
REQ-007 SHALL have port: in_divisor  input  2  divisor of offered pair.
REQ-008 SHALL have port: out_valid  output  1  head pair presented to the downstream 4-by-2 divider.
REQ-009 SHALL have port: out_ready  input  1  divider side consumes head pair this cycle.
REQ-010 SHALL have port: out_dividend  output  4  head dividend.
REQ-011 SHALL have port: out_divisor  output  2  head divisor.
REQ-012 SHALL have port: count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-013 SHALL have port: dbz_err  output  1  one-cycle pulse: zero-divisor pair dropped.

Function
REQ-014 SHALL implement a first-word-fall-through FIFO of {dividend, divisor} pairs, in-order.
REQ-015 SHALL drive in_ready = (count < DEPTH), combinational from registered state only.
REQ-016 SHALL push when in_valid && in_ready; pop when out_valid && out_ready.
REQ-017 SHALL assert out_valid the cycle after the first push into an empty queue (latency 1, no bypass).
REQ-018 SHALL drive out_valid = (count != 0) and present head entry on out_dividend/out_divisor.
REQ-019 SHALL force out_dividend and out_divisor to 0 while out_valid is low.
REQ-020 SHALL hold head data stable while out_valid && !out_ready.
REQ-021 SHALL, on simultaneous push and pop, keep count unchanged and advance both pointers.
REQ-022 SHALL, when full, keep in_ready low; no push that cycle even if a pop occurs.
REQ-023 SHALL wrap read/write pointers modulo DEPTH; count SHALL never exceed DEPTH nor underflow.
REQ-024 SHALL keep dbz_err low except as defined under Configuration.

Reset
REQ-025 SHALL, with rst high at a clock edge, set pointers 0, count 0, out_valid 0, out data 0, dbz_err 0.
REQ-026 SHALL, on reset mid-operation, discard all stored entries; handshakes in that cycle have no effect.
REQ-027 SHALL NOT require storage array reset; its contents are unobservable while empty.

Configuration
REQ-028 SHALL, with DIVQ_DBZ_FILTER_EN defined, complete the input handshake for a pair with in_divisor==0 without storing it and pulse dbz_err for exactly the following cycle.
REQ-029 SHALL, with DIVQ_DBZ_FILTER_EN defined, leave count unchanged by a dropped push (a same-cycle pop still decrements).
REQ-030 SHALL, without DIVQ_DBZ_FILTER_EN, store zero-divisor pairs like any other and tie dbz_err to 0.

Structure
REQ-031 SHALL take DIVIDEND_W=4, DIVISOR_W=2 and typedef div_op_t {dividend, divisor} from shared package div_pkg.
REQ-032 SHALL place the storage array in one sub-module divq_ram (DEPTH x div_op_t, 1 write port, 1 async read port).

Verification
REQ-033 SHALL cover: after reset push (9,2) at cycle 0, out_ready=1 -> out_valid high at cycle 1 with 9/2, count 1->0 at cycle 2.
REQ-034 SHALL cover: DEPTH=4, out_ready=0, push 5 pairs -> count=4, in_ready=0 after fourth, fifth not accepted, pop order matches push order.
REQ-035 SHALL cover: full queue, in_valid=1 and out_ready=1 same cycle -> count 3, no push; next cycle push accepted, count 4.
REQ-036 SHALL cover: 10 push/pop pairs at count=2 steady -> pointers wrap, data order intact, count stays 2.
REQ-037 SHALL cover (filter on): push (7,0) into empty queue -> dbz_err=1 next cycle only, count 0, out_valid 0; filter off -> out_valid 1 with 7/0.
REQ-038 SHALL cover: rst asserted with count=3 -> next cycle count 0, out_valid 0, out data 0, in_ready 1.
